// File: rtl/get_command_decoder.sv
// get_command_decoder: fetches one command word from a valid/read-enable
// source, splits it into opcode/arg1/arg2, range-checks the fields and
// reports a 2-bit error code (0 ok, 1 bad opcode, 2 arg2 range, 3 timeout).
module get_command_decoder #(
  parameter int          CMD_W   = 16,
  parameter int          OP_W    = 8,
  parameter int          A1_W    = 3,
  parameter int          A2_W    = 5,
  parameter int unsigned MAX_A2  = 10,
  parameter int unsigned TIMEOUT = 255,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_get_cmd,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] command_in,
  output logic             en_rd_cmd,
  output logic             done_get_cmd,
  output logic             busy,
  output logic [OP_W-1:0]  instr,
  output logic [A1_W-1:0]  arg1,
  output logic [A2_W-1:0]  arg2,
  output logic [1:0]       error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Error codes reported on the error port
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_ARG2    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Timeout is disabled entirely when TIMEOUT is zero; CNT_LAST is then unused
  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  instr_q, instr_d;
  logic [A1_W-1:0]  arg1_q, arg1_d;
  logic [A2_W-1:0]  arg2_q, arg2_d;
  logic [1:0]       error_q, error_d;
  logic             en_rd_q, en_rd_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Field views of the captured command word (all unsigned, no extension)
  logic [OP_W-1:0]  op_f;
  logic [A1_W-1:0]  a1_f;
  logic [A2_W-1:0]  a2_f;
  logic             a2_in_range;

  assign op_f = cmd_q[CMD_W-1 -: OP_W];
  assign a1_f = cmd_q[A2_W +: A1_W];
  assign a2_f = cmd_q[A2_W-1:0];
  // Compare at 32 bits so a MAX_A2 wider than the field never truncates
  assign a2_in_range = (32'(a2_f) <= MAX_A2);

  // Next-state, counter, capture and decode logic
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    arg1_d  = arg1_q;
    arg2_d  = arg2_q;
    error_d = error_q;

    case (state_q)
      S_IDLE: begin
        if (start_get_cmd) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end

      S_FETCH: begin
        // A word arriving on the timeout cycle still wins
        if (cmd_valid) begin
          cmd_d   = command_in;
          state_d = S_DECODE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          error_d = ERR_TIMEOUT;
          state_d = S_DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        state_d = S_DONE;
        if (op_f == OP_W'(0)) begin
          if (a2_in_range) begin
            instr_d = op_f;
            arg1_d  = a1_f;
            arg2_d  = a2_f;
            error_d = ERR_OK;
          end else begin
            error_d = ERR_ARG2;
          end
        end else if (op_f == OP_W'(1)) begin
          instr_d = op_f;
          arg1_d  = a1_f;
          arg2_d  = '0;
          error_d = ERR_OK;
        end else if (op_f == OP_W'(2)) begin
          instr_d = op_f;
          arg1_d  = a1_f;
          arg2_d  = a2_f;
          error_d = ERR_OK;
        end else if (op_f == OP_W'(3)) begin
          instr_d = op_f;
          arg1_d  = '0;
          arg2_d  = '0;
          error_d = ERR_OK;
        end else begin
          error_d = ERR_OPCODE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Moore outputs, precomputed from the next state so the flops track state
    en_rd_d = (state_d == S_FETCH);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      arg1_q  <= '0;
      arg2_q  <= '0;
      error_q <= ERR_OK;
      en_rd_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      arg1_q  <= arg1_d;
      arg2_q  <= arg2_d;
      error_q <= error_d;
      en_rd_q <= en_rd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign en_rd_cmd    = en_rd_q;
  assign done_get_cmd = done_q;
  assign busy         = busy_q;
  assign instr        = instr_q;
  assign arg1         = arg1_q;
  assign arg2         = arg2_q;
  assign error        = error_q;

endmodule

// File: tb/tb_get_command_decoder.sv
// Testbench for get_command_decoder: two instances (default-style fields with
// a short timeout, and overridden fields with timeout disabled) driven with
// directed and random fetches, checked against a field-arithmetic model.
module tb_get_command_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] command_in = '0;

  logic       en_a, done_a, busy_a;
  logic [7:0] instr_a;
  logic [2:0] arg1_a;
  logic [4:0] arg2_a;
  logic [1:0] err_a;

  logic       en_b, done_b, busy_b;
  logic [5:0] instr_b;
  logic [3:0] arg1_b;
  logic [5:0] arg2_b;
  logic [1:0] err_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-instance configuration seen by the model
  int cfg_op  [2] = '{8, 6};
  int cfg_a2w [2] = '{5, 6};
  int cfg_max [2] = '{10, 40};
  int cfg_to  [2] = '{4, 0};

  // Model of the held output registers per instance
  int m_instr [2] = '{0, 0};
  int m_a1    [2] = '{0, 0};
  int m_a2    [2] = '{0, 0};
  int m_err   [2] = '{0, 0};

  always #5 clk = ~clk;

  get_command_decoder #(
    .CMD_W(16), .OP_W(8), .A1_W(3), .A2_W(5),
    .MAX_A2(10), .TIMEOUT(4), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .start_get_cmd(start_a), .cmd_valid(cmd_valid),
    .command_in(command_in), .en_rd_cmd(en_a), .done_get_cmd(done_a),
    .busy(busy_a), .instr(instr_a), .arg1(arg1_a), .arg2(arg2_a), .error(err_a)
  );

  get_command_decoder #(
    .CMD_W(16), .OP_W(6), .A1_W(4), .A2_W(6),
    .MAX_A2(40), .TIMEOUT(0), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .start_get_cmd(start_b), .cmd_valid(cmd_valid),
    .command_in(command_in), .en_rd_cmd(en_b), .done_get_cmd(done_b),
    .busy(busy_b), .instr(instr_b), .arg1(arg1_b), .arg2(arg2_b), .error(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start_a = v;
    else        start_b = v;
  endtask

  task automatic sample(input int s, output logic [31:0] en, output logic [31:0] dn,
                        output logic [31:0] bz, output logic [31:0] ins,
                        output logic [31:0] a1, output logic [31:0] a2,
                        output logic [31:0] er);
    if (s == 0) begin
      en = 32'(en_a); dn = 32'(done_a); bz = 32'(busy_a);
      ins = 32'(instr_a); a1 = 32'(arg1_a); a2 = 32'(arg2_a); er = 32'(err_a);
    end else begin
      en = 32'(en_b); dn = 32'(done_b); bz = 32'(busy_b);
      ins = 32'(instr_b); a1 = 32'(arg1_b); a2 = 32'(arg2_b); er = 32'(err_b);
    end
  endtask

  // Reference decode: fields by shift/mask, rules by opcode value
  task automatic model_cmd(input int s, input int word);
    int op, a1, a2, a1w;
    a1w = 16 - cfg_op[s] - cfg_a2w[s];
    op  = word >> (16 - cfg_op[s]);
    a1  = (word >> cfg_a2w[s]) & ((1 << a1w) - 1);
    a2  = word & ((1 << cfg_a2w[s]) - 1);
    case (op)
      0: if (a2 <= cfg_max[s]) begin
           m_instr[s] = 0; m_a1[s] = a1; m_a2[s] = a2; m_err[s] = 0;
         end else begin
           m_err[s] = 2;
         end
      1: begin m_instr[s] = 1; m_a1[s] = a1; m_a2[s] = 0;  m_err[s] = 0; end
      2: begin m_instr[s] = 2; m_a1[s] = a1; m_a2[s] = a2; m_err[s] = 0; end
      3: begin m_instr[s] = 3; m_a1[s] = 0;  m_a2[s] = 0;  m_err[s] = 0; end
      default: m_err[s] = 1;
    endcase
  endtask

  task automatic chk_fields(input int s, input string tag);
    logic [31:0] en, dn, bz, ins, a1, a2, er;
    sample(s, en, dn, bz, ins, a1, a2, er);
    chk({tag, "_instr"}, ins, m_instr[s]);
    chk({tag, "_arg1"},  a1,  m_a1[s]);
    chk({tag, "_arg2"},  a2,  m_a2[s]);
    chk({tag, "_error"}, er,  m_err[s]);
  endtask

  // One request: called when the next cycle is IDLE. The word is offered on
  // FETCH cycle index 'delay' (0 = first FETCH cycle). Cycle-by-cycle Moore
  // outputs and the final fields are compared with the model.
  task automatic do_fetch(input int s, input logic [15:0] word, input int delay,
                          input bit next_b2b);
    int to, fetch_len, done_n;
    bit timed_out;
    logic [31:0] en, dn, bz, ins, a1, a2, er;
    to        = cfg_to[s];
    timed_out = (to != 0) && (delay >= to);
    fetch_len = timed_out ? to : delay + 1;
    done_n    = timed_out ? to + 1 : delay + 3;

    @(negedge clk);
    sample(s, en, dn, bz, ins, a1, a2, er);
    chk("idle_busy", bz, 0);
    chk("idle_en",   en, 0);
    chk("idle_done", dn, 0);
    set_start(s, 1'b1);
    cmd_valid  = 1'($urandom % 2);
    command_in = 16'($urandom);

    for (int n = 1; n <= done_n; n++) begin
      @(negedge clk);
      sample(s, en, dn, bz, ins, a1, a2, er);
      chk("en_rd", en, 32'(n <= fetch_len));
      chk("busy",  bz, 1);
      chk("done",  dn, 32'(n == done_n));
      if (n == done_n) begin
        if (timed_out) m_err[s] = 3;
        else           model_cmd(s, int'(word));
        chk_fields(s, timed_out ? "timeout" : "decode");
        set_start(s, next_b2b);
        cmd_valid  = 1'($urandom % 2);
        command_in = 16'($urandom);
      end else begin
        set_start(s, 1'($urandom % 2));
        if (n <= fetch_len) begin
          cmd_valid  = !timed_out && (n == fetch_len);
          command_in = cmd_valid ? word : 16'($urandom);
        end else begin
          cmd_valid  = 1'($urandom % 2);
          command_in = 16'($urandom);
        end
      end
    end
    $display("fetch dut=%0d word=%h delay=%0d b2b=%0b -> instr=%0d arg1=%0d arg2=%0d err=%0d",
             s, word, delay, next_b2b, ins, a1, a2, er);
  endtask

  initial begin
    logic [31:0] en, dn, bz, ins, a1, a2, er;
    int   s;
    bit   b2b;
    logic [15:0] w;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sample(i, en, dn, bz, ins, a1, a2, er);
      chk("rst_en", en, 0); chk("rst_done", dn, 0); chk("rst_busy", bz, 0);
      chk_fields(i, "rst");
    end
    rst = 1'b1;

    // Directed decode cases on the default-width instance
    do_fetch(0, 16'h014A, 0, 1'b0);   // op1: arg2 forced to 0
    do_fetch(0, 16'h006A, 0, 1'b0);   // op0, arg2 = MAX_A2
    do_fetch(0, 16'h006B, 1, 1'b0);   // op0, arg2 = MAX_A2+1 -> error 2
    do_fetch(0, 16'h05FF, 2, 1'b0);   // illegal opcode -> error 1
    do_fetch(0, 16'h03FF, 0, 1'b0);   // op3
    do_fetch(0, 16'h02AB, 10, 1'b0);  // no word -> timeout after 4 FETCH cycles
    do_fetch(0, 16'h02AB, 3, 1'b0);   // word on the 4th FETCH cycle wins
    do_fetch(0, 16'h0155, 0, 1'b1);   // start held through DONE
    do_fetch(0, 16'h0241, 1, 1'b0);   // back-to-back fetch

    // Reset asserted during DECODE aborts with no done pulse
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; cmd_valid = 1'b1; command_in = 16'h0262;
    @(negedge clk);
    sample(0, en, dn, bz, ins, a1, a2, er);
    chk("dec_busy", bz, 1); chk("dec_en", en, 0);
    cmd_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      m_instr[i] = 0; m_a1[i] = 0; m_a2[i] = 0; m_err[i] = 0;
    end
    sample(0, en, dn, bz, ins, a1, a2, er);
    chk("abort_busy", bz, 0); chk("abort_done", dn, 0); chk("abort_en", en, 0);
    chk_fields(0, "abort");
    rst = 1'b1;
    @(negedge clk);
    sample(0, en, dn, bz, ins, a1, a2, er);
    chk("abort_nodone", dn, 0); chk("abort_idle", bz, 0);
    $display("reset during DECODE -> busy=%0d done=%0d", bz, dn);

    // Overridden widths, timeout disabled
    do_fetch(1, 16'h097F, 0, 1'b0);   // op2, arg2 = 63
    do_fetch(1, 16'h0069, 0, 1'b0);   // op0, arg2 = 41 -> error 2
    do_fetch(1, 16'h0068, 30, 1'b0);  // long wait, no timeout; arg2 = 40 ok

    // Random fetches on both instances
    s = 0; b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!b2b) s = int'($urandom % 2);
      w = 16'($urandom);
      if (s == 0) w[15:8]  = 8'($urandom % 6);
      else        w[15:10] = 6'($urandom % 6);
      b2b = 1'($urandom % 2);
      if (i == 39) b2b = 1'b0;
      do_fetch(s, w, int'($urandom % 7), b2b);
    end

    // Final done must be a single-cycle pulse
    @(negedge clk);
    sample(s, en, dn, bz, ins, a1, a2, er);
    chk("final_done", dn, 0); chk("final_busy", bz, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/get_command_decoder.md
Name: get_command_decoder

Overview:
Parametrised command fetch/decode FSM for the polynomial evaluation accelerator. It pops one command word from the command source using a valid/read-enable handshake. It splits the word into opcode, arg1 and arg2, range-checks it and reports a 2-bit error code. Compared with the previous fixed-width generation it adds generic field widths, a configurable arg2 bound, a source-valid handshake in place of an external mode strobe, a fetch timeout and a busy flag.

Parameters:
CMD_W, 16, command word width
OP_W, 8, opcode field width (bits CMD_W-1 down to CMD_W-OP_W)
A1_W, 3, arg1 field width (directly below opcode)
A2_W, 5, arg2 field width (bits A2_W-1:0); OP_W+A1_W+A2_W must equal CMD_W
MAX_A2, 10, largest legal arg2 for opcode 0 (unsigned compare, inclusive)
TIMEOUT, 255, FETCH cycles without cmd_valid before timeout error; 0 disables timeout
CNT_W, 8, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
start_get_cmd  in  1  request one command fetch; sampled only in IDLE
cmd_valid  in  1  command_in holds a valid word
command_in  in  CMD_W  command word from source
en_rd_cmd  out  1  read enable to source; word consumed on a cycle with en_rd_cmd=1 and cmd_valid=1
done_get_cmd  out  1  one-cycle pulse: decode or timeout finished, outputs valid
busy  out  1  high whenever state is not IDLE
instr  out  OP_W  registered opcode
arg1  out  A1_W  registered arg1
arg2  out  A2_W  registered arg2
error  out  2  0 ok, 1 illegal opcode, 2 arg2 out of range, 3 fetch timeout

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; instr, arg1, arg2, error, cmd_reg and timeout counter all 0. en_rd_cmd, done_get_cmd and busy are 0 in the following cycle. Reset mid-operation aborts immediately and no done pulse follows.
- en_rd_cmd, done_get_cmd and busy are decoded from state only (Moore outputs).
- States:
  - IDLE: if start_get_cmd=1, go to FETCH and clear the counter; otherwise stay.
  - FETCH: en_rd_cmd=1.
    - If cmd_valid=1: capture command_in into cmd_reg and go to DECODE.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1: set error=3 (instr/arg1/arg2 hold) and go to DONE.
    - Else: counter+1 and stay.
    - cmd_valid wins if it arrives on the timeout cycle.
  - DECODE: en_rd_cmd=0. Outputs are registered at the end of this cycle from cmd_reg:
    - op 0: if arg2<=MAX_A2, load instr/arg1/arg2 and set error=0; otherwise error=2 and instr/arg1/arg2 hold previous values.
    - op 1: instr, arg1 loaded; arg2=0; error=0.
    - op 2: instr, arg1, arg2 loaded; error=0.
    - op 3: instr loaded; arg1=0, arg2=0; error=0.
    - any other op: error=1; instr/arg1/arg2 hold.
    - Go to DONE.
  - DONE: done_get_cmd=1 for exactly one cycle; go to IDLE. Outputs are stable from this cycle until the next DECODE or timeout.
- Latency: start at cycle t, FETCH at t+1. If cmd_valid first seen at cycle t+1+k, DECODE is at t+2+k and done_get_cmd plus new outputs appear at t+3+k. Minimum request-to-done is 3 cycles.
- Exactly one word is consumed per fetch. start_get_cmd outside IDLE is ignored and not queued. cmd_valid outside FETCH is ignored.
- Back-to-back: start_get_cmd held high through DONE re-enters FETCH on the cycle after IDLE is reached (IDLE lasts one cycle).
- All field extraction is unsigned with no sign extension. The counter saturates and never wraps within one fetch.

Test Plan:
- Reset then start=1, cmd_valid=1 with 0x014A (op1, arg1=2, arg2=10) -> done at start+3, instr=1, arg1=2, arg2=0, error=0, en_rd_cmd high exactly 1 cycle.
- op0: 0x006A (arg1=3, arg2=10) -> instr=0, arg1=3, arg2=10, error=0; then 0x006B (arg2=11) -> error=2, instr/arg1/arg2 unchanged.
- op 0x05 word 0x05FF -> error=1, fields hold; next op3 word 0x03FF -> instr=3, arg1=0, arg2=0, error=0.
- Start with cmd_valid low, TIMEOUT=4 -> en_rd_cmd high 4 cycles, then done with error=3. Repeat with cmd_valid rising on the 4th FETCH cycle -> normal decode, no error 3.
- Pulse start in FETCH and DECODE, and cmd_valid in IDLE -> no effect, single done per request; rst=0 in DECODE -> IDLE next cycle, all outputs 0, no done pulse.
- Override OP_W=6, A1_W=4, A2_W=6, MAX_A2=40: op2 word with arg2=63 -> arg2=63, error=0; op0 with arg2=41 -> error=2.
